// File: rtl/enc_op4_xe_if.sv
// Command-in / halfword-out bundle for the enc_op4_xe instruction re-encoder.
// master drives commands and takes words; slave is the encoder.
interface enc_op4_xe_if;
  logic        icmdValid;
  logic        ocmdReady;
  logic [3:0]  icmdForm;
  logic [3:0]  icmdOp;
  logic [6:0]  icmdRegN;
  logic [6:0]  icmdRegS;
  logic [6:0]  icmdRegT;
  logic [31:0] icmdImm;
  logic [15:0] owordData;
  logic        owordValid;
  logic        iwordReady;
  logic        owordLast;
  logic        oerr;

  modport master (
    output icmdValid, icmdForm, icmdOp, icmdRegN, icmdRegS, icmdRegT, icmdImm, iwordReady,
    input  ocmdReady, owordData, owordValid, owordLast, oerr
  );

  modport slave (
    input  icmdValid, icmdForm, icmdOp, icmdRegN, icmdRegS, icmdRegT, icmdImm, iwordReady,
    output ocmdReady, owordData, owordValid, owordLast, oerr
  );
endinterface

// File: rtl/enc_op4_xe.sv
// Instruction re-encoder: turns one decoded command into the shortest 16-bit word stream,
// either a single opcode word or an 8Exx prefix followed by the opcode word.
module enc_op4_xe (
  input logic         clock,
  input logic         reset,
  enc_op4_xe_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPfx  = 2'd1;
  localparam logic [1:0] StCmd  = 2'd2;

  logic [1:0]  r_state, w_state_d;
  logic [15:0] r_data, w_data_d;
  logic [15:0] r_cmd, w_cmd_d;
  logic        r_last, w_last_d;
  logic        r_err, w_err_d;

  logic        w_fit8, w_fit12, w_fit16, w_fit20, w_imm_zero;
  logic        w_n_int, w_s_int, w_t_int, w_n_fpu, w_s_fpu, w_t_fpu;
  logic        w_legal, w_long, w_accept;
  logic [15:0] w_pfx, w_opc;

  // Value fits in k signed bits when every bit from k-1 upward equals the sign bit.
  assign w_fit8     = (&bus.icmdImm[31:7])  | ~(|bus.icmdImm[31:7]);
  assign w_fit12    = (&bus.icmdImm[31:11]) | ~(|bus.icmdImm[31:11]);
  assign w_fit16    = (&bus.icmdImm[31:15]) | ~(|bus.icmdImm[31:15]);
  assign w_fit20    = (&bus.icmdImm[31:19]) | ~(|bus.icmdImm[31:19]);
  assign w_imm_zero = ~(|bus.icmdImm);

  assign w_n_int = (bus.icmdRegN[6:4] == 3'b000);
  assign w_s_int = (bus.icmdRegS[6:4] == 3'b000);
  assign w_t_int = (bus.icmdRegT[6:4] == 3'b000);
  assign w_n_fpu = (bus.icmdRegN[6:4] == 3'b100);
  assign w_s_fpu = (bus.icmdRegS[6:4] == 3'b100);
  assign w_t_fpu = (bus.icmdRegT[6:4] == 3'b100);

  always_comb begin
    w_legal = 1'b0;
    w_long  = 1'b0;
    w_pfx   = 16'h8E00;
    w_opc   = 16'h0000;
    case (bus.icmdForm)
      4'd0, 4'd1: begin
        w_opc   = {(bus.icmdForm == 4'd0) ? 4'h7 : 4'hE, bus.icmdRegN[3:0], bus.icmdImm[7:0]};
        w_pfx   = {8'h8E, bus.icmdImm[15:8]};
        w_legal = w_n_int & w_fit16;
        w_long  = ~w_fit8;
      end
      4'd2, 4'd3: begin
        w_opc   = {(bus.icmdForm == 4'd2) ? 4'hA : 4'hB, bus.icmdImm[11:0]};
        w_pfx   = {8'h8E, bus.icmdImm[19:12]};
        w_legal = w_fit20;
        w_long  = ~w_fit12;
      end
      4'd4, 4'd5: begin
        w_opc   = {(bus.icmdForm == 4'd4) ? 4'h2 : 4'h6, bus.icmdRegN[3:0], bus.icmdRegS[3:0],
                   2'b00, bus.icmdOp[1:0]};
        w_pfx   = {8'h8E, bus.icmdImm[7:0]};
        w_legal = w_n_int & w_s_int & w_fit8;
        w_long  = ~w_imm_zero;
      end
      4'd6: begin
        w_opc  = {4'h4, bus.icmdRegN[3:0], bus.icmdOp, 4'h3};
        w_pfx  = {8'h8E, bus.icmdRegS[3:0], bus.icmdRegT[3:0]};
        w_long = 1'b1;
        // Ops 0-9 run on the integer file, C/D/E on the FPU file; the rest are undefined.
        if (bus.icmdOp <= 4'd9) begin
          w_legal = w_n_int & w_s_int & w_t_int;
        end else if (bus.icmdOp >= 4'hC && bus.icmdOp <= 4'hE) begin
          w_legal = w_n_fpu & w_s_fpu & w_t_fpu;
        end
      end
      default: ;
    endcase
  end

  assign bus.ocmdReady = (r_state == StIdle) | ((r_state == StCmd) & bus.iwordReady);
  assign w_accept      = bus.icmdValid & bus.ocmdReady;

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_last_d  = r_last;
    w_cmd_d   = r_cmd;
    w_err_d   = 1'b0;
    case (r_state)
      StPfx: begin
        if (bus.iwordReady) begin
          w_state_d = StCmd;
          w_data_d  = r_cmd;
          w_last_d  = 1'b1;
        end
      end
      StIdle, StCmd: begin
        if (w_accept) begin
          if (!w_legal) begin
            w_state_d = StIdle;
            w_data_d  = 16'h0000;
            w_last_d  = 1'b0;
            w_err_d   = 1'b1;
          end else if (w_long) begin
            w_state_d = StPfx;
            w_data_d  = w_pfx;
            w_last_d  = 1'b0;
            w_cmd_d   = w_opc;
          end else begin
            w_state_d = StCmd;
            w_data_d  = w_opc;
            w_last_d  = 1'b1;
          end
        end else if (r_state == StCmd && bus.iwordReady) begin
          w_state_d = StIdle;
          w_data_d  = 16'h0000;
          w_last_d  = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_data_d  = 16'h0000;
        w_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_data  <= 16'h0000;
      r_cmd   <= 16'h0000;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_cmd   <= w_cmd_d;
      r_last  <= w_last_d;
      r_err   <= w_err_d;
    end
  end

  assign bus.owordValid = (r_state == StPfx) | (r_state == StCmd);
  assign bus.owordData  = r_data;
  assign bus.owordLast  = r_last;
  assign bus.oerr       = r_err;

endmodule

// File: tb/tb_enc_op4_xe.sv
// Self-checking bench for enc_op4_xe: directed spec examples, randomized commands against a
// range-based reference model, backpressure, back-to-back and mid-instruction reset.
module tb_enc_op4_xe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  enc_op4_xe_if bus ();

  enc_op4_xe u_dut (
    .clock(clk),
    .reset(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [16:0] obs_q[$];
  logic [16:0] exp_q[$];
  bit          exp_err;
  logic        obs_err_first, obs_valid_first, obs_err_after, obs_valid_after, obs_rdy_after;
  int          obs_glitch, obs_timeout;

  typedef struct {
    logic [3:0]  form;
    logic [3:0]  op;
    logic [6:0]  n, s, t;
    logic [31:0] imm;
    int          nw;
    logic [16:0] w0, w1;
    bit          err;
  } dcase_t;

  function automatic dcase_t mk(input logic [3:0] form, op, input logic [6:0] n, s, t,
                                input logic [31:0] imm, input int nw,
                                input logic [16:0] w0, w1, input bit err);
    dcase_t d;
    d.form = form; d.op = op; d.n = n; d.s = s; d.t = t; d.imm = imm;
    d.nw = nw; d.w0 = w0; d.w1 = w1; d.err = err;
    return d;
  endfunction

  // Reference: shortest encoding from signed-range rules; entries are {last, word}.
  task automatic model(input logic [3:0] form, op, input logic [6:0] n, s, t,
                       input logic [31:0] imm);
    int v, ni, si, ti, o, nib, p, c;
    exp_q.delete();
    exp_err = 1'b0;
    v = $signed(imm); ni = int'(n); si = int'(s); ti = int'(t); o = int'(op);
    p = -1; c = -1;
    case (form)
      4'd0, 4'd1: begin
        nib = (form == 4'd0) ? 7 : 14;
        c = nib * 4096 + (ni % 16) * 256 + (v & 255);
        if (ni > 15 || v < -32768 || v > 32767) exp_err = 1'b1;
        else if (v < -128 || v > 127) p = 16'h8E00 + ((v >>> 8) & 255);
      end
      4'd2, 4'd3: begin
        nib = (form == 4'd2) ? 10 : 11;
        c = nib * 4096 + (v & 4095);
        if (v < -524288 || v > 524287) exp_err = 1'b1;
        else if (v < -2048 || v > 2047) p = 16'h8E00 + ((v >>> 12) & 255);
      end
      4'd4, 4'd5: begin
        nib = (form == 4'd4) ? 2 : 6;
        c = nib * 4096 + (ni % 16) * 256 + (si % 16) * 16 + (o % 4);
        if (ni > 15 || si > 15 || v < -128 || v > 127) exp_err = 1'b1;
        else if (v != 0) p = 16'h8E00 + (v & 255);
      end
      4'd6: begin
        c = 16'h4000 + (ni % 16) * 256 + o * 16 + 3;
        p = 16'h8E00 + (si % 16) * 16 + (ti % 16);
        if (o <= 9) begin
          if (ni > 15 || si > 15 || ti > 15) exp_err = 1'b1;
        end else if (o >= 12 && o <= 14) begin
          if (ni < 64 || ni > 79 || si < 64 || si > 79 || ti < 64 || ti > 79) exp_err = 1'b1;
        end else exp_err = 1'b1;
      end
      default: exp_err = 1'b1;
    endcase
    if (!exp_err) begin
      if (p >= 0) exp_q.push_back({1'b0, p[15:0]});
      exp_q.push_back({1'b1, c[15:0]});
    end
  endtask

  // Issues one command and records every word handed over, plus stall stability.
  task automatic issue(input logic [3:0] form, op, input logic [6:0] n, s, t,
                       input logic [31:0] imm, input bit rnd);
    int k;
    bit stalled, rdy;
    logic [15:0] held;
    obs_q.delete();
    obs_glitch = 0; obs_timeout = 0; stalled = 1'b0; held = '0;
    bus.icmdForm = form; bus.icmdOp = op; bus.icmdRegN = n; bus.icmdRegS = s;
    bus.icmdRegT = t; bus.icmdImm = imm; bus.icmdValid = 1'b1;
    k = 0;
    while (!bus.ocmdReady && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) obs_timeout++;
    @(posedge clk); #1;
    bus.icmdValid = 1'b0;
    bus.icmdForm = 4'($urandom); bus.icmdOp = 4'($urandom); bus.icmdRegN = 7'($urandom);
    bus.icmdRegS = 7'($urandom); bus.icmdRegT = 7'($urandom); bus.icmdImm = $urandom;
    obs_err_first = bus.oerr;
    obs_valid_first = bus.owordValid;
    k = 0;
    while (bus.owordValid && k < 100) begin
      if (stalled && bus.owordData !== held) obs_glitch++;
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.iwordReady = rdy;
      held = bus.owordData;
      if (rdy) obs_q.push_back({bus.owordLast, bus.owordData});
      stalled = !rdy;
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) obs_timeout++;
    bus.iwordReady = 1'b0;
    @(posedge clk); #1;
    obs_err_after = bus.oerr;
    obs_valid_after = bus.owordValid;
    obs_rdy_after = bus.ocmdReady;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.owordValid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", bus.owordValid); end
    checks++; if (bus.owordData !== 16'h0000) begin errors++;
      $display("FAIL reset_data got %h want 0000", bus.owordData); end
    checks++; if (bus.owordLast !== 1'b0 || bus.oerr !== 1'b0) begin errors++;
      $display("FAIL reset_last_err got %b%b want 00", bus.owordLast, bus.oerr); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.ocmdReady !== 1'b1) begin errors++;
      $display("FAIL reset_ready got %b want 1", bus.ocmdReady); end
  endtask

  task automatic test_directed();
    dcase_t d[$];
    d.push_back(mk(4'd0, 4'd0, 7'h03, 7'h00, 7'h00, 32'd5,        1, 17'h17305, 17'h0, 0));
    d.push_back(mk(4'd0, 4'd0, 7'h03, 7'h00, 7'h00, 32'h1234,     2, 17'h08E12, 17'h17334, 0));
    d.push_back(mk(4'd1, 4'd0, 7'h01, 7'h00, 7'h00, -32'sd200,    2, 17'h08EFF, 17'h1E138, 0));
    d.push_back(mk(4'd2, 4'd0, 7'h00, 7'h00, 7'h00, 32'h12345,    2, 17'h08E12, 17'h1A345, 0));
    d.push_back(mk(4'd6, 4'd0, 7'h05, 7'h01, 7'h02, 32'd0,        2, 17'h08E12, 17'h14503, 0));
    d.push_back(mk(4'd6, 4'hC, 7'h05, 7'h01, 7'h02, 32'd0,        0, 17'h0, 17'h0, 1));
    d.push_back(mk(4'd0, 4'd0, 7'h03, 7'h00, 7'h00, 32'h12345,    0, 17'h0, 17'h0, 1));
    d.push_back(mk(4'd4, 4'd1, 7'h02, 7'h03, 7'h00, 32'd0,        1, 17'h12231, 17'h0, 0));
    d.push_back(mk(4'd5, 4'd3, 7'h04, 7'h05, 7'h00, 32'hFFFFFFFF, 2, 17'h08EFF, 17'h16453, 0));
    d.push_back(mk(4'd6, 4'hD, 7'h41, 7'h42, 7'h4F, 32'd0,        2, 17'h08E2F, 17'h141D3, 0));
    d.push_back(mk(4'd2, 4'd0, 7'h00, 7'h00, 7'h00, -32'sd2048,   1, 17'h1A800, 17'h0, 0));
    d.push_back(mk(4'd3, 4'd0, 7'h00, 7'h00, 7'h00, 32'd2048,     2, 17'h08E00, 17'h1B800, 0));
    d.push_back(mk(4'd0, 4'd0, 7'h10, 7'h00, 7'h00, 32'd1,        0, 17'h0, 17'h0, 1));
    d.push_back(mk(4'd7, 4'd0, 7'h00, 7'h00, 7'h00, 32'd0,        0, 17'h0, 17'h0, 1));
    d.push_back(mk(4'd4, 4'd0, 7'h00, 7'h00, 7'h00, 32'd128,      0, 17'h0, 17'h0, 1));
    d.push_back(mk(4'd0, 4'd0, 7'h00, 7'h00, 7'h00, 32'd127,      1, 17'h1707F, 17'h0, 0));
    d.push_back(mk(4'd0, 4'd0, 7'h00, 7'h00, 7'h00, -32'sd128,    1, 17'h17080, 17'h0, 0));
    d.push_back(mk(4'd0, 4'd0, 7'h00, 7'h00, 7'h00, 32'd32767,    2, 17'h08E7F, 17'h170FF, 0));
    d.push_back(mk(4'd0, 4'd0, 7'h00, 7'h00, 7'h00, -32'sd32769,  0, 17'h0, 17'h0, 1));
    foreach (d[i]) begin
      issue(d[i].form, d[i].op, d[i].n, d[i].s, d[i].t, d[i].imm, 1'b0);
      checks++; if (obs_err_first !== d[i].err || obs_timeout != 0) begin errors++;
        $display("FAIL dir%0d_err got %b (timeouts %0d) want %b", i, obs_err_first,
                 obs_timeout, d[i].err); end
      checks++; if (obs_q.size() != d[i].nw) begin errors++;
        $display("FAIL dir%0d_count got %0d want %0d", i, obs_q.size(), d[i].nw); end
      else begin
        if (d[i].nw > 0) begin checks++; if (obs_q[0] !== d[i].w0) begin errors++;
          $display("FAIL dir%0d_w0 got %h want %h", i, obs_q[0], d[i].w0); end end
        if (d[i].nw > 1) begin checks++; if (obs_q[1] !== d[i].w1) begin errors++;
          $display("FAIL dir%0d_w1 got %h want %h", i, obs_q[1], d[i].w1); end end
      end
      if (d[i].err) begin
        checks++; if (obs_valid_first !== 1'b0) begin errors++;
          $display("FAIL dir%0d_err_valid got %b want 0", i, obs_valid_first); end
      end
      checks++; if ({obs_err_after, obs_valid_after, obs_rdy_after} !== 3'b001) begin errors++;
        $display("FAIL dir%0d_after got err/valid/rdy %b%b%b want 001", i, obs_err_after,
                 obs_valid_after, obs_rdy_after); end
    end
  endtask

  task automatic test_random();
    logic [3:0] form, op;
    logic [6:0] n, s, t;
    logic [31:0] imm;
    bit fpu;
    for (int i = 0; i < 80; i++) begin
      form = 4'($urandom_range(0, 8));
      fpu = (form == 4'd6) && ($urandom_range(0, 1) == 1);
      op = (form == 4'd4 || form == 4'd5) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      n = fpu ? 7'h40 | 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 15));
      s = fpu ? 7'h40 | 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 15));
      t = fpu ? 7'h40 | 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) n = 7'($urandom);
      case ($urandom_range(0, 5))
        0: imm = 32'($urandom_range(0, 255)) - 32'd128;
        1: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: imm = 32'($urandom_range(0, 65535)) - 32'd32768;
        3: imm = 32'($urandom_range(0, 1048575)) - 32'd524288;
        4: imm = $urandom;
        default: imm = 32'd0;
      endcase
      model(form, op, n, s, t, imm);
      issue(form, op, n, s, t, imm, 1'b1);
      checks++; if (obs_err_first !== exp_err || obs_timeout != 0) begin errors++;
        $display("FAIL rnd%0d_err got %b (timeouts %0d) want %b", i, obs_err_first,
                 obs_timeout, exp_err); end
      checks++; if (obs_q.size() != exp_q.size()) begin errors++;
        $display("FAIL rnd%0d_count got %0d want %0d", i, obs_q.size(), exp_q.size()); end
      else foreach (exp_q[j]) begin
        checks++; if (obs_q[j] !== exp_q[j]) begin errors++;
          $display("FAIL rnd%0d_w%0d got %h want %h", i, j, obs_q[j], exp_q[j]); end
      end
      checks++; if (obs_glitch != 0) begin errors++;
        $display("FAIL rnd%0d_stall_stable got %0d changes want 0", i, obs_glitch); end
      checks++; if ({obs_err_after, obs_valid_after, obs_rdy_after} !== 3'b001) begin errors++;
        $display("FAIL rnd%0d_after got %b%b%b want 001", i, obs_err_after, obs_valid_after,
                 obs_rdy_after); end
    end
  endtask

  task automatic test_backpressure();
    bus.icmdForm = 4'd0; bus.icmdOp = 4'd0; bus.icmdRegN = 7'h03; bus.icmdRegS = 7'h00;
    bus.icmdRegT = 7'h00; bus.icmdImm = 32'h1234; bus.icmdValid = 1'b1; bus.iwordReady = 1'b0;
    @(posedge clk); #1;
    bus.icmdValid = 1'b0; bus.icmdImm = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.owordValid, bus.owordLast, bus.owordData, bus.ocmdReady} !==
                    {1'b1, 1'b0, 16'h8E12, 1'b0}) begin errors++;
        $display("FAIL bp_pfx%0d got v%b l%b %h r%b want v1 l0 8e12 r0", i, bus.owordValid,
                 bus.owordLast, bus.owordData, bus.ocmdReady); end
      @(posedge clk); #1;
    end
    bus.iwordReady = 1'b1;
    @(posedge clk); #1;
    bus.iwordReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if ({bus.owordValid, bus.owordLast, bus.owordData} !== {2'b11, 16'h7334})
      begin errors++;
        $display("FAIL bp_cmd%0d got v%b l%b %h want v1 l1 7334", i, bus.owordValid,
                 bus.owordLast, bus.owordData); end
      @(posedge clk); #1;
    end
    bus.iwordReady = 1'b1;
    @(posedge clk); #1;
    bus.iwordReady = 1'b0;
    checks++; if (bus.owordValid !== 1'b0) begin errors++;
      $display("FAIL bp_done got %b want 0", bus.owordValid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] imms[3];
    logic [3:0]  forms[3];
    logic [15:0] words[3];
    imms  = '{32'd1, 32'hFFFFFFFF, 32'h123};
    forms = '{4'd0, 4'd1, 4'd2};
    words = '{16'h7101, 16'hE2FF, 16'hA123};
    bus.iwordReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.icmdForm = forms[i]; bus.icmdRegN = 7'(i + 1); bus.icmdImm = imms[i];
      bus.icmdValid = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus.owordValid, bus.owordLast, bus.owordData} !== {2'b11, words[i]})
      begin errors++;
        $display("FAIL b2b_w%0d got v%b l%b %h want v1 l1 %h", i, bus.owordValid,
                 bus.owordLast, bus.owordData, words[i]); end
    end
    bus.icmdValid = 1'b0;
    @(posedge clk); #1;
    bus.iwordReady = 1'b0;
    checks++; if (bus.owordValid !== 1'b0) begin errors++;
      $display("FAIL b2b_done got %b want 0", bus.owordValid); end
  endtask

  task automatic test_reset_mid();
    bus.icmdForm = 4'd6; bus.icmdOp = 4'd1; bus.icmdRegN = 7'h05; bus.icmdRegS = 7'h01;
    bus.icmdRegT = 7'h02; bus.icmdValid = 1'b1; bus.iwordReady = 1'b0;
    @(posedge clk); #1;
    bus.icmdValid = 1'b0;
    checks++; if ({bus.owordValid, bus.owordData} !== {1'b1, 16'h8E12}) begin errors++;
      $display("FAIL rst_mid_pfx got v%b %h want v1 8e12", bus.owordValid, bus.owordData); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.owordValid, bus.owordData, bus.owordLast} !== 18'h0) begin errors++;
      $display("FAIL rst_mid_clear got v%b %h l%b want v0 0000 l0", bus.owordValid,
               bus.owordData, bus.owordLast); end
    @(negedge clk); rst_n = 1'b1; bus.iwordReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.owordValid !== 1'b0) begin errors++;
        $display("FAIL rst_mid_quiet%0d got %b want 0", i, bus.owordValid); end
    end
    bus.iwordReady = 1'b0;
  endtask

  initial begin
    bus.icmdValid = 1'b0; bus.icmdForm = '0; bus.icmdOp = '0; bus.icmdRegN = '0;
    bus.icmdRegS = '0; bus.icmdRegT = '0; bus.icmdImm = '0; bus.iwordReady = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
